// File: rtl/weight_fetch_ctrl.sv
// Purpose: streams DEPTH weight words, in ascending address order, from a negedge-clocked BRAM onto a valid/ready stream.
// Latency: one cycle from read issue to capture; first word valid one cycle after START; sustains 1 word/cycle.
// Backpressure: reads are issued only while the 2-entry skid FIFO plus the in-flight read leave room; W_DATA holds until accepted.
//
// Ports:
//   CLK, RST_N        - clock, asynchronous active-low reset
//   START             - begin a full pass (sampled in IDLE only)
//   BUSY, DONE        - pass in progress / one-cycle end-of-pass pulse
//   BRAM_ADDR/EN/WE   - registered BRAM read port (WE always 0)
//   BRAM_DO           - BRAM read data, valid the cycle after a read
//   W_DATA/IDX/LAST   - FIFO head: weight, its address, last-word marker
//   W_VALID, W_READY  - stream handshake
module weight_fetch_ctrl #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] BRAM_ADDR,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DO,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_IDX,
  output logic          W_LAST,
  output logic          W_VALID,
  input  logic          W_READY
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        state, state_nxt;
  logic          issue;
  logic [AW-1:0] addr_nxt;
  logic          done_nxt;

  // 2-entry FIFO holding captured words and the address they came from
  logic [DW-1:0] fifo_dat [2];
  logic [AW-1:0] fifo_idx [2];
  logic          wr_ptr, rd_ptr;
  logic [1:0]    fifo_cnt;

  logic          push, pop, room;
  logic [2:0]    occ;

  // A read issued on the previous edge is always captured on this one,
  // so BRAM_EN doubles as the in-flight flag.
  assign push = BRAM_EN;
  assign pop  = W_VALID & W_READY;

  // Occupancy after this edge if nothing new is issued; keep it below 2
  // so the read issued now still has a slot when it lands.
  assign occ  = 3'(fifo_cnt) + 3'(BRAM_EN) - 3'(pop);
  assign room = (occ < 3'd2);

  assign BUSY    = (state != IDLE);
  assign W_VALID = (fifo_cnt != 2'd0);
  assign W_DATA  = fifo_dat[rd_ptr];
  assign W_IDX   = fifo_idx[rd_ptr];
  assign W_LAST  = W_VALID && (W_IDX == LAST_ADDR);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    addr_nxt  = BRAM_ADDR;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          issue     = 1'b1;
          addr_nxt  = '0;
          state_nxt = (LAST_ADDR == '0) ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        if (room) begin
          issue    = 1'b1;
          addr_nxt = BRAM_ADDR + AW'(1);
          if (addr_nxt == LAST_ADDR) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && W_LAST) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BRAM_ADDR <= '0;
      BRAM_EN   <= 1'b0;
      BRAM_WE   <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      BRAM_ADDR <= addr_nxt;
      BRAM_EN   <= issue;
      BRAM_WE   <= 1'b0;
      DONE      <= done_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fifo_dat[0] <= '0;
      fifo_dat[1] <= '0;
      fifo_idx[0] <= '0;
      fifo_idx[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_dat[wr_ptr] <= BRAM_DO;
        fifo_idx[wr_ptr] <= BRAM_ADDR;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  overflow_chk: assert property (@(posedge CLK) disable iff (!RST_N)
    !(push && !pop && fifo_cnt == 2'd2));

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Purpose: self-checking bench for weight_fetch_ctrl with a negedge BRAM model and a stream-level reference model.
// Latency: the reference model expects one word per accepted handshake, in address order, with DONE the cycle after the last.
// Backpressure: W_READY is driven directed, held low, or random; the model bounds outstanding reads to two.
module tb_weight_fetch_ctrl;

  localparam int NW = 28;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        BUSY;
  logic        DONE;
  logic [4:0]  BRAM_ADDR;
  logic        BRAM_EN;
  logic        BRAM_WE;
  logic [15:0] BRAM_DO;
  logic [15:0] W_DATA;
  logic [4:0]  W_IDX;
  logic        W_LAST;
  logic        W_VALID;
  logic        W_READY;

  logic [15:0] bram [NW];

  int error_cnt = 0;
  int check_cnt = 0;

  // reference model state
  bit busy_m, done_exp, prev_hold;
  int exp_rd, exp_hs, issued, popped, pass_hs, done_cnt;
  logic [15:0] prev_dat;
  logic [4:0]  prev_idx;

  weight_fetch_ctrl #(.DEPTH(NW), .AW(5), .DW(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(BUSY), .DONE(DONE),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_DO(BRAM_DO),
    .W_DATA(W_DATA), .W_IDX(W_IDX), .W_LAST(W_LAST), .W_VALID(W_VALID), .W_READY(W_READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // BRAM updates its output on the falling edge
  always @(negedge CLK) begin
    if (BRAM_EN) BRAM_DO <= bram[BRAM_ADDR];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act !== exp) begin
      error_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Stream-level model: the head of the stream is always the next unaccepted
  // word of the pass, reads are sequential, and at most two words are ever
  // issued but not yet consumed.
  task automatic model_loop();
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        busy_m = 0; done_exp = 0; prev_hold = 0;
        exp_rd = 0; exp_hs = 0; issued = 0; popped = 0;
      end else begin
        check("bram_we", 32'(BRAM_WE), 0);
        check("busy", 32'(BUSY), 32'(busy_m));
        check("done", 32'(DONE), 32'(done_exp));
        if (DONE) done_cnt++;
        done_exp = 0;
        if (BRAM_EN) begin
          check("rd_addr", 32'(BRAM_ADDR), (exp_rd < NW) ? exp_rd : 32'hFFFF_FFFF);
          exp_rd++;
          issued++;
        end
        check("outstanding_gt2", 32'(issued - popped > 2), 0);
        if (prev_hold) begin
          check("hold_valid", 32'(W_VALID), 1);
          check("hold_data", 32'(W_DATA), 32'(prev_dat));
          check("hold_idx", 32'(W_IDX), 32'(prev_idx));
        end
        if (!busy_m) check("idle_valid", 32'(W_VALID), 0);
        if (W_VALID) begin
          check("head_idx", 32'(W_IDX), exp_hs);
          check("head_data", 32'(W_DATA), exp_hs + 100);
          check("head_last", 32'(W_LAST), 32'(exp_hs == NW - 1));
        end else begin
          check("last_without_valid", 32'(W_LAST), 0);
        end
        prev_hold = W_VALID && !W_READY;
        prev_dat  = W_DATA;
        prev_idx  = W_IDX;
        if (!busy_m && START) begin
          busy_m = 1; exp_rd = 0; exp_hs = 0; issued = 0; popped = 0; pass_hs = 0;
        end else if (busy_m && W_VALID && W_READY) begin
          if (exp_hs == NW - 1) begin
            busy_m   = 0;
            done_exp = 1;
          end
          exp_hs++; popped++; pass_hs++;
        end
      end
    end
  endtask

  task automatic run_until_done(input int max_cyc, input bit rnd);
    bit got;
    got = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      if (rnd) W_READY = 1'($urandom_range(0, 1));
      tick();
      if (DONE) got = 1;
    end
    W_READY = 1'b1;
    check("done_seen", 32'(got), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_done"}, 32'(DONE), 0);
    check({tag, "_addr"}, 32'(BRAM_ADDR), 0);
    check({tag, "_en"}, 32'(BRAM_EN), 0);
    check({tag, "_we"}, 32'(BRAM_WE), 0);
    check({tag, "_valid"}, 32'(W_VALID), 0);
    check({tag, "_data"}, 32'(W_DATA), 0);
    check({tag, "_idx"}, 32'(W_IDX), 0);
    check({tag, "_last"}, 32'(W_LAST), 0);
  endtask

  initial begin
    int d0;
    for (int i = 0; i < NW; i++) bram[i] = 16'(i + 100);
    done_cnt = 0;
    pass_hs  = 0;
    RST_N    = 1'b1;
    START    = 1'b0;
    W_READY  = 1'b0;
    fork
      model_loop();
    join_none
    #1 RST_N = 1'b0;
    #1 check_all_zero("por");
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    tick();

    // free run, ready held high: first word after k+1, last after k+28, DONE after k+29
    d0 = done_cnt;
    W_READY = 1'b1;
    START = 1'b1; tick(); START = 1'b0;
    check("fr_en0", 32'(BRAM_EN), 1);
    check("fr_addr0", 32'(BRAM_ADDR), 0);
    check("fr_busy0", 32'(BUSY), 1);
    check("fr_valid0", 32'(W_VALID), 0);
    tick();
    check("fr_valid1", 32'(W_VALID), 1);
    check("fr_data1", 32'(W_DATA), 100);
    check("fr_idx1", 32'(W_IDX), 0);
    repeat (27) tick();
    check("fr_data28", 32'(W_DATA), 127);
    check("fr_last28", 32'(W_LAST), 1);
    check("fr_idx28", 32'(W_IDX), 27);
    check("fr_done28", 32'(DONE), 0);
    tick();
    check("fr_done29", 32'(DONE), 1);
    check("fr_busy29", 32'(BUSY), 0);
    check("fr_valid29", 32'(W_VALID), 0);
    tick();
    check("fr_done30", 32'(DONE), 0);
    check("fr_done_count", done_cnt - d0, 1);
    check("fr_handshakes", pass_hs, NW);

    // backpressure: consumer stalls for 10 cycles after the first word
    W_READY = 1'b0;
    START = 1'b1; tick(); START = 1'b0;
    tick();
    check("bp_first_valid", 32'(W_VALID), 1);
    check("bp_first_data", 32'(W_DATA), 100);
    repeat (10) tick();
    check("bp_reads_issued", issued, 2);
    check("bp_head_held", 32'(W_DATA), 100);
    W_READY = 1'b1;
    run_until_done(100, 1'b0);
    check("bp_handshakes", pass_hs, NW);
    tick();

    // random ready
    d0 = done_cnt;
    START = 1'b1; tick(); START = 1'b0;
    run_until_done(400, 1'b1);
    check("rnd_handshakes", pass_hs, NW);
    tick();
    check("rnd_done_count", done_cnt - d0, 1);

    // START mid-FETCH is ignored; START on the DONE cycle restarts at address 0
    d0 = done_cnt;
    START = 1'b1; tick(); START = 1'b0;
    repeat (5) tick();
    START = 1'b1; tick(); START = 1'b0;
    check("rs_still_busy", 32'(BUSY), 1);
    run_until_done(100, 1'b0);
    check("rs_handshakes1", pass_hs, NW);
    START = 1'b1; tick(); START = 1'b0;
    check("rs_restart_en", 32'(BRAM_EN), 1);
    check("rs_restart_addr", 32'(BRAM_ADDR), 0);
    check("rs_restart_busy", 32'(BUSY), 1);
    run_until_done(100, 1'b0);
    check("rs_handshakes2", pass_hs, NW);
    tick();
    check("rs_done_count", done_cnt - d0, 2);

    // reset mid-FETCH: outputs clear with no clock edge
    START = 1'b1; tick(); START = 1'b0;
    repeat (5) tick();
    check("rf_busy_before", 32'(BUSY), 1);
    RST_N = 1'b0;
    #1 check_all_zero("rst_fetch");
    tick(); tick();
    RST_N = 1'b1;
    tick();

    // reset during DRAIN: aborted pass never pulses DONE, next pass is clean
    d0 = done_cnt;
    START = 1'b1; tick(); START = 1'b0;
    repeat (28) tick();
    check("rd_last_pending", 32'(W_LAST), 1);
    RST_N = 1'b0;
    #1 check_all_zero("rst_drain");
    tick(); tick();
    RST_N = 1'b1;
    tick(); tick();
    check("rd_idle_after_release", 32'(BUSY), 0);
    check("rd_no_abort_done", done_cnt - d0, 0);
    START = 1'b1; tick(); START = 1'b0;
    check("rd_new_addr", 32'(BRAM_ADDR), 0);
    run_until_done(100, 1'b0);
    check("rd_handshakes", pass_hs, NW);
    tick();
    check("rd_done_count", done_cnt - d0, 1);

    $display("Result: errors=%0d of %0d checks", error_cnt, check_cnt);
    $finish;
  end

endmodule
